// File: rtl/trojan_trigger_gen.sv
// rtl/trojan_trigger_gen.sv - qualified-event counter that raises a trigger at a threshold
// Optional fire_cnt output when TROJAN_FIRE_CNT_EN is defined.
module trojan_trigger_gen #(
    parameter int                SEL_W     = 4,
    parameter int                CNT_W     = 13,
    parameter int                THRESH    = 4096,
    parameter logic [SEL_W-1:0]  INC_MASK  = 4'b1100,
    parameter logic [SEL_W-1:0]  CLR_MASK  = 4'b1111,
    parameter logic [SEL_W-1:0]  CLR_VAL   = 4'b1101,
    parameter bit                STICKY    = 1'b1,
    parameter int                PULSE_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    output logic             trigger,
    output logic [CNT_W-1:0] count,
    output logic             armed
`ifdef TROJAN_FIRE_CNT_EN
    ,
    output logic [7:0]       fire_cnt
`endif
);

    localparam int PW = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);
    localparam logic [PW-1:0]    PULSE_C  = PW'(PULSE_LEN);

    // Count must reach THRESH without wrapping.
    if (THRESH < 1 || THRESH > ((1 << CNT_W) - 1)) begin : g_bad_thresh
        $error("trojan_trigger_gen: THRESH must be in 1 .. 2**CNT_W-1");
    end
    if (PULSE_LEN < 1) begin : g_bad_pulse
        $error("trojan_trigger_gen: PULSE_LEN must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [CNT_W-1:0] w_count_inc;
    logic [PW-1:0]    r_pulse;
    logic [PW-1:0]    w_pulse_nxt;
    logic             r_trigger;
    logic             r_armed;
    logic             w_inc;
    logic             w_clr;

    assign w_inc       = (sel & INC_MASK) != '0;
    assign w_clr       = (sel & CLR_MASK) == CLR_VAL;
    assign w_count_inc = r_count + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_pulse_nxt = r_pulse;
        case (r_state)
            IDLE: begin
                w_count_nxt = '0;
                if (en) begin
                    w_state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (en) begin
                    if (w_clr) begin
                        w_count_nxt = '0;
                    end else if (w_inc) begin
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == THRESH_C) begin
                            w_state_nxt = FIRED;
                            w_pulse_nxt = PULSE_C;
                        end
                    end
                end
            end
            FIRED: begin
                // Pulse counter holds the remaining high cycles, including the current one.
                if (!STICKY) begin
                    if (r_pulse <= PW'(1)) begin
                        w_state_nxt = COUNT;
                        w_count_nxt = '0;
                        w_pulse_nxt = '0;
                    end else begin
                        w_pulse_nxt = r_pulse - PW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
                w_pulse_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_count   <= '0;
            r_pulse   <= '0;
            r_trigger <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_pulse   <= w_pulse_nxt;
            r_trigger <= (w_state_nxt == FIRED);
            r_armed   <= (w_state_nxt == COUNT);
        end
    end

    assign trigger = r_trigger;
    assign count   = r_count;
    assign armed   = r_armed;

`ifdef TROJAN_FIRE_CNT_EN
    logic [7:0] r_fire_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fire_cnt <= '0;
        end else if (w_state_nxt == FIRED && r_state != FIRED && r_fire_cnt != 8'hFF) begin
            r_fire_cnt <= r_fire_cnt + 8'd1;
        end
    end

    assign fire_cnt = r_fire_cnt;
`endif

endmodule

// File: tb/tb_trojan_trigger_gen.sv
// tb/tb_trojan_trigger_gen.sv - scoreboard bench for trojan_trigger_gen, sticky and pulse instances
module tb_trojan_trigger_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s = 1'b1, en_s = 1'b0;
    logic [3:0] sel_s = 4'b0;
    logic       trig_s, arm_s;
    logic [3:0] cnt_s;
    logic [7:0] fc_s;

    logic       rst_p = 1'b1, en_p = 1'b0;
    logic [3:0] sel_p = 4'b0;
    logic       trig_p, arm_p;
    logic [3:0] cnt_p;
    logic [7:0] fc_p;

    trojan_trigger_gen #(.CNT_W(4), .THRESH(8), .STICKY(1'b1)) dut_s (
        .clk(clk), .rst(rst_s), .en(en_s), .sel(sel_s),
        .trigger(trig_s), .count(cnt_s), .armed(arm_s)
`ifdef TROJAN_FIRE_CNT_EN
        , .fire_cnt(fc_s)
`endif
    );

    trojan_trigger_gen #(.CNT_W(4), .THRESH(8), .STICKY(1'b0), .PULSE_LEN(4)) dut_p (
        .clk(clk), .rst(rst_p), .en(en_p), .sel(sel_p),
        .trigger(trig_p), .count(cnt_p), .armed(arm_p)
`ifdef TROJAN_FIRE_CNT_EN
        , .fire_cnt(fc_p)
`endif
    );

`ifndef TROJAN_FIRE_CNT_EN
    assign fc_s = 8'd0;
    assign fc_p = 8'd0;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         p;
        logic       t;
        logic [3:0] c;
        logic       a;
        int         fc;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   tag     = 0;

    task automatic step(input bit p, input logic r, input logic e, input logic [3:0] s,
                        input logic t, input logic [3:0] c, input logic a, input int fc = -1);
        if (p) begin
            rst_p = r; en_p = e; sel_p = s;
        end else begin
            rst_s = r; en_s = e; sel_s = s;
        end
        q.push_back('{cyc: cyc + 1, p: p, t: t, c: c, a: a, fc: fc, tag: tag});
        @(posedge clk);
        #1;
    endtask

    exp_t       m_e;
    logic       m_t, m_a, m_ok;
    logic [3:0] m_c;
    int         m_f;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e = q.pop_front();
            m_t = m_e.p ? trig_p : trig_s;
            m_c = m_e.p ? cnt_p  : cnt_s;
            m_a = m_e.p ? arm_p  : arm_s;
            m_f = int'(m_e.p ? fc_p : fc_s);
            m_ok = (m_e.cyc == cyc) && (m_t === m_e.t) && (m_c === m_e.c) && (m_a === m_e.a);
`ifdef TROJAN_FIRE_CNT_EN
            if (m_e.fc >= 0 && m_f != m_e.fc) m_ok = 1'b0;
`endif
            n_total++;
            if (m_ok) begin
                n_pass++;
            end else begin
                $display("FAIL step tag=%0d cyc=%0d dut=%s got trig=%b count=%0d armed=%b fire_cnt=%0d expected trig=%b count=%0d armed=%b fire_cnt=%0d",
                         m_e.tag, cyc, m_e.p ? "pulse" : "sticky", m_t, m_c, m_a, m_f,
                         m_e.t, m_e.c, m_e.a, m_e.fc);
            end
        end
    end

    initial begin
        // Reset state and IDLE ignoring sel
        tag = 0;
        step(0, 1, 0, 4'b0000, 0, 0, 0, 0);
        step(1, 1, 0, 4'b0000, 0, 0, 0, 0);
        step(0, 0, 0, 4'b1000, 0, 0, 0, 0);

        // Threshold: arm, then 8 qualifying samples; sticky FIRED ignores clear
        tag = 1;
        step(0, 0, 1, 4'b1000, 0, 0, 1);
        for (int i = 1; i <= 8; i++) step(0, 0, 1, 4'b1000, (i == 8), 4'(i), (i != 8), (i == 8) ? 1 : 0);
        step(0, 0, 1, 4'b1101, 1, 8, 0, 1);
        step(0, 0, 1, 4'b1101, 1, 8, 0, 1);
        step(0, 0, 0, 4'b1101, 1, 8, 0, 1);

        // Clear priority, non-qualifying pattern, reset mid-count
        tag = 2;
        step(0, 1, 0, 4'b0000, 0, 0, 0, 0);
        step(0, 0, 1, 4'b0000, 0, 0, 1);
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 4'b0100, 0, 4'(i), 1);
        step(0, 0, 1, 4'b1101, 0, 0, 1);
        repeat (10) step(0, 0, 1, 4'b0011, 0, 0, 1);
        step(0, 0, 1, 4'b1000, 0, 1, 1);
        step(0, 0, 1, 4'b1000, 0, 2, 1);
        step(0, 1, 1, 4'b1000, 0, 0, 0, 0);

        // Enable low holds count and stays armed
        tag = 3;
        step(0, 0, 1, 4'b0000, 0, 0, 1);
        for (int i = 1; i <= 3; i++) step(0, 0, 1, 4'b1000, 0, 4'(i), 1);
        repeat (5) step(0, 0, 0, 4'b0100, 0, 3, 1);
        for (int i = 1; i <= 5; i++) step(0, 0, 1, 4'b0100, (i == 5), 4'(3 + i), (i != 5));

        // Pulse mode: exactly 4 high cycles, back to COUNT at 0, re-fire
        tag = 4;
        step(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) step(1, 0, 1, 4'b1000, (i == 8), 4'(i), (i != 8), (i == 8) ? 1 : 0);
        for (int k = 1; k <= 3; k++) step(1, 0, 1, 4'b1101, 1, 8, 0, 1);
        step(1, 0, 1, 4'b1000, 0, 0, 1, 1);
        for (int i = 1; i <= 8; i++) step(1, 0, 1, 4'b1000, (i == 8), 4'(i), (i != 8), (i == 8) ? 2 : 1);

        // Reset two cycles into FIRED
        tag = 5;
        step(1, 1, 0, 4'b0000, 0, 0, 0, 0);
        step(1, 0, 1, 4'b0000, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++) step(1, 0, 1, 4'b1000, (i == 8), 4'(i), (i != 8), (i == 8) ? 1 : 0);
        step(1, 0, 1, 4'b1000, 1, 8, 0, 1);
        step(1, 1, 1, 4'b1000, 0, 0, 0, 0);
        step(1, 0, 0, 4'b1000, 0, 0, 0, 0);
        step(1, 0, 1, 4'b1000, 0, 0, 1, 0);

        repeat (2) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain got %0d pending expectations expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trojan_trigger_gen.md
TROJAN_TRIGGER_GEN -- requirements
Module: trojan_trigger_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SEL_W, 4: width of monitored select vector.
- CNT_W, 13: event counter width.
- THRESH, 4096: qualifying-event count that fires trigger; 1 <= THRESH <= 2^CNT_W-1.
- INC_MASK, 4'b1100: increment qualifier; event when (sel & INC_MASK) != 0.
- CLR_MASK, 4'b1111: clear qualifier mask.
- CLR_VAL, 4'b1101: clear when (sel & CLR_MASK) == CLR_VAL.
- STICKY, 1: 1 = trigger held until reset; 0 = pulse mode.
- PULSE_LEN, 4: trigger high-time in pulse mode, in cycles, >= 1.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: single clock, all state on rising edge.
- rst, in, 1: synchronous reset, active-high.
- en, in, 1: counting enable.
- sel, in, SEL_W: monitored vector.
- trigger, out, 1: fire indication, registered.
- count, out, CNT_W: current event count, registered.
- armed, out, 1: high in COUNT state.

Function
REQ-003 FSM SHALL have states IDLE, COUNT, FIRED; trigger = (state == FIRED); armed = (state == COUNT).
REQ-004 IDLE SHALL go to COUNT on the first edge with en = 1; count stays 0 in IDLE and sel is ignored.
REQ-005 In COUNT with en = 1, a clear match SHALL load count = 0, taking priority over a simultaneous increment match.
REQ-006 In COUNT with en = 1, an increment match without a clear match SHALL add 1 to count.
REQ-007 In COUNT with en = 0, count SHALL hold, and the FSM SHALL stay in COUNT (never returns to IDLE except via rst).
REQ-008 When an increment brings count to THRESH, the FSM SHALL enter FIRED on that same edge; trigger goes high in the next cycle (one edge after the THRESH-th qualifying sample).
REQ-009 In FIRED, count SHALL freeze at THRESH; sel and en SHALL be ignored, including clear matches.
REQ-010 With STICKY = 1, FIRED SHALL persist until rst.
REQ-011 With STICKY = 0, trigger SHALL stay high exactly PULSE_LEN cycles, then the FSM returns to COUNT with count = 0 on the same edge.
REQ-012 A pulse-length down-counter SHALL be internal, of width clog2(PULSE_LEN+1), and loaded on entry to FIRED.
REQ-013 count SHALL never wrap; THRESH < 2^CNT_W guarantees this and SHALL be checked by an elaboration-time error.

Reset
REQ-014 rst = 1 at a clk edge SHALL force state IDLE, count 0, pulse counter 0, and trigger 0, overriding any simultaneous event.
REQ-015 Outputs SHALL be trigger = 0, count = 0, armed = 0 in the cycle after reset, including rst asserted mid-count or mid-pulse.

Configuration
REQ-016 With macro TROJAN_FIRE_CNT_EN defined, the block SHALL add output fire_cnt [7:0]:
- counts entries into FIRED.
- saturates at 255.
- cleared by rst.
REQ-017 Without TROJAN_FIRE_CNT_EN, the fire_cnt port and its logic SHALL be absent, with all other behaviour identical.

Verification
(Bench parameters unless noted: THRESH = 8, CNT_W = 4, defaults otherwise.)
REQ-018 Scenario, threshold:
- Stimulus: rst, then en = 1 with sel = 4'b1000 for 8 cycles.
- Response: count steps 1..8; trigger = 1 from the cycle after the 8th edge; armed = 0.
REQ-019 Scenario, clear priority:
- Stimulus: count at 5, then sel = 4'b1101.
- Response: count = 0 next cycle, trigger stays 0.
- Then: sel = 4'b0011 for 10 cycles gives count = 0 throughout.
REQ-020 Scenario, enable:
- Stimulus: count at 3, then en = 0 with sel = 4'b0100 for 5 cycles.
- Response: count stays 3; en = 1 for 5 more cycles fires trigger.
REQ-021 Scenario, pulse mode (STICKY = 0, PULSE_LEN = 4):
- Stimulus: reach threshold.
- Response: trigger high exactly 4 cycles; then count = 0 and armed = 1; 8 further events re-fire.
REQ-022 Scenario, reset mid-pulse:
- Stimulus: rst asserted 2 cycles into FIRED.
- Response: trigger = 0, count = 0, state IDLE next cycle.
- With TROJAN_FIRE_CNT_EN: fire_cnt = 1 before rst, 0 after.
